// File: rtl/inst_mem.sv
// Instruction memory with a streaming loader.
// LOAD phase: words arrive on the ld_* handshake and are written in order.
// RUN phase: one fetch per cycle, with the result presented one cycle later.
// Indices at or above loaded_words read as 0 (nop). Bad addresses raise addr_err.
module inst_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  addr_err,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic                  reload,
  output logic [DEPTH_LOG2:0]   loaded_words
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LAST_IDX = (DEPTH_LOG2 + 1)'(DEPTH - 1);
  localparam logic [DEPTH_LOG2:0] ONE      = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic                  ld_ready_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  hit_q;
  logic [31:0]           rd_q;

  // Storage is intentionally not reset: count_q gates visibility of stale words.
  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic                  bad_addr;
  logic                  in_loaded;
  logic                  wr_en;
  logic                  rd_en;

  assign fetch_idx = pc[DEPTH_LOG2+1:2];
  // Misaligned, or any bit set above the addressable byte range.
  assign bad_addr  = (|pc[1:0]) || (|(pc >> (DEPTH_LOG2 + 2)));
  assign in_loaded = ({1'b0, fetch_idx} < count_q);
  assign wr_en     = (state_q == S_LOAD) && ld_valid && (count_q != FULL);
  // A reload in the same cycle cancels the fetch.
  assign rd_en     = (state_q == S_RUN) && ce && !reload;

  // Control FSM: phase, word counter and registered fetch status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      ld_ready_q <= 1'b1;
      count_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (ld_valid) begin
            if (count_q != FULL) begin
              count_q <= count_q + ONE;
            end
            if (ld_last || (count_q == LAST_IDX)) begin
              state_q    <= S_RUN;
              ld_ready_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (reload) begin
            state_q    <= S_LOAD;
            ld_ready_q <= 1'b1;
            count_q    <= '0;
          end else if (ce) begin
            valid_q <= 1'b1;
            err_q   <= bad_addr;
            hit_q   <= !bad_addr && in_loaded;
          end
        end
        default: begin
          state_q    <= S_LOAD;
          ld_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Load port: each accepted beat is written to the next free word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[DEPTH_LOG2-1:0]] <= ld_data;
    end
  end

  // Fetch port: registered read, so the memory maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_q <= mem[fetch_idx];
    end
  end

  assign inst         = hit_q ? rd_q : 32'h0000_0000;
  assign inst_valid   = valid_q;
  assign addr_err     = err_q;
  assign ld_ready     = ld_ready_q;
  assign loaded_words = count_q;

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: a default-depth instance and a DEPTH_LOG2=2 instance share stimulus.
// A behavioural model predicts both instances, and the DUTs are compared to it every cycle.
// Directed scenarios add literal expectations, followed by a randomized phase.
module tb_inst_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        ce       = 1'b0;
  logic [31:0] pc       = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data  = '0;
  logic        ld_last  = 1'b0;
  logic        reload   = 1'b0;

  logic [31:0] inst_b, inst_s;
  logic        v_b, v_s, e_b, e_s, r_b, r_s;
  logic [10:0] lw_b;
  logic [2:0]  lw_s;

  inst_mem u_big (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc),
    .inst(inst_b), .inst_valid(v_b), .addr_err(e_b),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(r_b), .reload(reload), .loaded_words(lw_b)
  );

  inst_mem #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc),
    .inst(inst_s), .inst_valid(v_s), .addr_err(e_s),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(r_s), .reload(reload), .loaded_words(lw_s)
  );

  // ---------------- behavioural model ----------------
  int        depth [2] = '{1024, 4};
  bit        m_run [2];
  int        m_cnt [2];
  bit [31:0] m_mem [2][1024];
  bit [31:0] x_inst [2];
  bit        x_v [2];
  bit        x_err [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k]  = 1'b0;
      m_cnt[k]  = 0;
      x_inst[k] = '0;
      x_v[k]    = 1'b0;
      x_err[k]  = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!m_run[k]) begin
        x_inst[k] = '0; x_v[k] = 1'b0; x_err[k] = 1'b0;
        if (ld_valid) begin
          m_mem[k][m_cnt[k]] = ld_data;
          m_cnt[k]++;
          if (ld_last || m_cnt[k] == depth[k]) m_run[k] = 1'b1;
        end
      end else if (reload) begin
        m_run[k] = 1'b0; m_cnt[k] = 0;
        x_inst[k] = '0; x_v[k] = 1'b0; x_err[k] = 1'b0;
      end else if (ce) begin
        x_v[k] = 1'b1;
        if ((pc % 4) != 0 || longint'(pc) >= 4 * longint'(depth[k])) begin
          x_inst[k] = '0; x_err[k] = 1'b1;
        end else if (int'(pc / 4) >= m_cnt[k]) begin
          x_inst[k] = '0; x_err[k] = 1'b0;
        end else begin
          x_inst[k] = m_mem[k][pc / 4]; x_err[k] = 1'b0;
        end
      end else begin
        x_inst[k] = '0; x_v[k] = 1'b0; x_err[k] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("big.inst",          inst_b, x_inst[0]);
    chk("big.inst_valid",    32'(v_b), 32'(x_v[0]));
    chk("big.addr_err",      32'(e_b), 32'(x_err[0]));
    chk("big.ld_ready",      32'(r_b), 32'(!m_run[0]));
    chk("big.loaded_words",  32'(lw_b), 32'(m_cnt[0]));
    chk("small.inst",        inst_s, x_inst[1]);
    chk("small.inst_valid",  32'(v_s), 32'(x_v[1]));
    chk("small.addr_err",    32'(e_s), 32'(x_err[1]));
    chk("small.ld_ready",    32'(r_s), 32'(!m_run[1]));
    chk("small.loaded_words", 32'(lw_s), 32'(m_cnt[1]));
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_step();
  end

  initial forever begin
    @(posedge rst);
    model_reset();
  end

  initial forever begin
    @(negedge clk);
    compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ce = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; reload = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    ce = 1'b1; pc = a;
    @(negedge clk);
    ce = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("lit.reset_ld_ready", 32'(r_b), 32'd1);
    chk("lit.reset_loaded",   32'(lw_b), 32'd0);
    chk("lit.reset_valid",    32'(v_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three-word program, then sequential fetch.
    beat(32'h2401_0001, 1'b0);
    beat(32'h2402_0002, 1'b0);
    beat(32'h0022_1820, 1'b1);
    chk("lit.load3_loaded", 32'(lw_b), 32'd3);
    chk("lit.load3_ready",  32'(r_b), 32'd0);
    ce = 1'b1; pc = 32'h0;
    @(negedge clk);
    chk("lit.pc0_inst", inst_b, 32'h2401_0001);
    chk("lit.pc0_valid", 32'(v_b), 32'd1);
    pc = 32'h4;
    @(negedge clk);
    chk("lit.pc4_inst", inst_b, 32'h2402_0002);
    pc = 32'h8;
    @(negedge clk);
    chk("lit.pc8_inst", inst_b, 32'h0022_1820);
    pc = 32'hC;
    @(negedge clk);
    chk("lit.pcC_inst", inst_b, 32'h0);
    chk("lit.pcC_valid", 32'(v_b), 32'd1);
    chk("lit.pcC_err", 32'(e_b), 32'd0);
    pc = 32'h2;
    @(negedge clk);
    chk("lit.pc2_err", 32'(e_b), 32'd1);
    chk("lit.pc2_inst", inst_b, 32'h0);
    pc = 32'h1000;
    @(negedge clk);
    chk("lit.pc1000_err", 32'(e_b), 32'd1);
    chk("lit.pc1000_valid", 32'(v_b), 32'd1);
    ce = 1'b0;
    @(negedge clk);
    chk("lit.ce0_valid", 32'(v_b), 32'd0);

    // Reload with a same-cycle fetch, then a one-word program.
    reload = 1'b1; ce = 1'b1; pc = 32'h0;
    @(negedge clk);
    idle();
    chk("lit.reload_valid", 32'(v_b), 32'd0);
    chk("lit.reload_ready", 32'(r_b), 32'd1);
    chk("lit.reload_loaded", 32'(lw_b), 32'd0);
    beat(32'hDEAD_BEEF, 1'b1);
    fetch(32'h0);
    chk("lit.newword_inst", inst_b, 32'hDEAD_BEEF);

    // Fill without ld_last: the small instance enters RUN after the 4th beat.
    reload = 1'b1;
    @(negedge clk);
    idle();
    beat(32'h0000_0011, 1'b0);
    beat(32'h0000_0022, 1'b0);
    beat(32'h0000_0033, 1'b0);
    beat(32'h0000_0044, 1'b0);
    chk("lit.full_small_loaded", 32'(lw_s), 32'd4);
    chk("lit.full_small_ready", 32'(r_s), 32'd0);
    beat(32'h0000_0055, 1'b1);
    chk("lit.full_small_ignore", 32'(lw_s), 32'd4);
    chk("lit.full_big_loaded", 32'(lw_b), 32'd5);
    fetch(32'hC);
    chk("lit.full_small_inst", inst_s, 32'h0000_0044);

    // Asynchronous reset in the middle of a load.
    reload = 1'b1;
    @(negedge clk);
    idle();
    beat(32'hAAAA_0001, 1'b0);
    beat(32'hAAAA_0002, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("lit.async_loaded", 32'(lw_b), 32'd0);
    chk("lit.async_ready", 32'(r_b), 32'd1);
    chk("lit.async_valid", 32'(v_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0);
    chk("lit.post_rst_load_valid", 32'(v_b), 32'd0);
    chk("lit.post_rst_load_inst", inst_b, 32'h0);
    beat(32'h5555_0000, 1'b1);
    fetch(32'h4);
    chk("lit.stale_inst", inst_b, 32'h0);
    chk("lit.stale_valid", 32'(v_b), 32'd1);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_data  = $urandom;
      ld_last  = ($urandom_range(0, 5) == 0);
      ce       = ($urandom_range(0, 3) != 0);
      reload   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 4))
        0: pc = $urandom_range(0, 5) * 4;
        1: pc = $urandom_range(0, 1030) * 4;
        2: pc = $urandom_range(0, 40);
        3: pc = $urandom;
        default: pc = $urandom_range(0, 3) * 4;
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
